adc_serial_rx: RTL and testbench

- Serial capture front end for the LT5534 detector's 12-bit SPI-style ADC (cs / sclk / so pins); drives the ADC pins and returns parallel samples.
- Controls detector enable with a settle delay, runs back-to-back conversions while `run` is high, and hands samples downstream through a one-entry valid/ready register.
- Sits between the top-level pads and sample-processing logic in the 50 MHz PLL domain.

---
 rtl/adc_serial_rx.sv | 213 +++++++++++++++++++++
 tb/tb_adc_serial_rx.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: LT5534 12-bit serial ADC capture with detector settle and output register.
// Define ADC_AVG_EN to average 2**AVG_LOG2 frames per delivered sample.
module adc_serial_rx #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int QUIET_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int AVG_LOG2      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear_flags,
    input  logic                 adc_so,
    output logic                 adc_cs,
    output logic                 adc_sclk,
    output logic                 det_en,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 lead_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_QUIET  = 2'd3;

    localparam int MAXC = (SETTLE_CYCLES > QUIET_CYCLES) ? SETTLE_CYCLES : QUIET_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(FRAME_BITS + 1);

    if (CLK_DIV < 3 || CLK_DIV > 255 || QUIET_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        DATA_BITS >= FRAME_BITS || AVG_LOG2 < 1 || AVG_LOG2 > 16) begin : g_bad_param
        $error("adc_serial_rx: illegal parameter set");
    end

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [7:0]            div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  so_m;
    logic                  so_s;
    logic                  frame_done;
    logic                  frame_lead;
    logic [DATA_BITS-1:0]  frame_word;
    logic                  offer;
    logic [DATA_BITS-1:0]  offer_data;
    logic                  load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            so_m <= 1'b0;
            so_s <= 1'b0;
        end else begin
            so_m <= adc_so;
            so_s <= so_m;
        end
    end

    // cs/sclk are registered so reset forces them high without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            adc_cs     <= 1'b1;
            adc_sclk   <= 1'b1;
            det_en     <= 1'b0;
            cnt        <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
            frame_lead <= 1'b0;
            frame_word <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_lead <= 1'b0;
            case (state)
                ST_IDLE: begin
                    adc_cs   <= 1'b1;
                    adc_sclk <= 1'b1;
                    if (run && !det_en) begin
                        det_en <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_SETTLE;
                    end else if (run) begin
                        state    <= ST_CONV;
                        adc_cs   <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!run) begin
                        det_en <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        state    <= ST_CONV;
                        adc_cs   <= 1'b0;
                        adc_sclk <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CONV: begin
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (adc_sclk && bit_cnt == BW'(FRAME_BITS)) begin
                            state      <= ST_QUIET;
                            adc_cs     <= 1'b1;
                            cnt        <= '0;
                            frame_done <= 1'b1;
                            frame_word <= shreg[DATA_BITS-1:0];
                            frame_lead <= |shreg[FRAME_BITS-1:DATA_BITS];
                        end else if (adc_sclk) begin
                            adc_sclk <= 1'b0;
                        end else begin
                            adc_sclk <= 1'b1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= {shreg[FRAME_BITS-2:0], so_s};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CW'(QUIET_CYCLES - 1)) begin
                        if (run) begin
                            state    <= ST_CONV;
                            adc_cs   <= 1'b0;
                            adc_sclk <= 1'b1;
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            det_en <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ADC_AVG_EN
    localparam int AW = DATA_BITS + AVG_LOG2;

    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt;

    assign acc_sum    = acc + AW'(frame_word);
    assign offer      = frame_done && (&avg_cnt);
    assign offer_data = acc_sum[AW-1:AVG_LOG2];

    // partial averages are dropped whenever the converter goes idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (state == ST_IDLE) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (frame_done) begin
            if (&avg_cnt) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                avg_cnt <= avg_cnt + 1'b1;
            end
        end
    end
`else
    assign offer      = frame_done;
    assign offer_data = frame_word;
`endif

    assign load = offer && (!sample_valid || sample_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            lead_err     <= 1'b0;
        end else begin
            if (load) begin
                sample_data  <= offer_data;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (offer && !load) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (frame_lead) begin
                lead_err <= 1'b1;
            end else if (clear_flags) begin
                lead_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// tb_adc_serial_rx: drives adc_serial_rx with an ADC pin model and checks
// samples, pin timing, backpressure, flags, run drop and reset against rules.
module tb_adc_serial_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        clear_flags = 1'b0;
    logic        adc_so = 1'b0;
    logic        adc_cs;
    logic        adc_sclk;
    logic        det_en;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        overrun;
    logic        lead_err;

    adc_serial_rx dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .clear_flags  (clear_flags),
        .adc_so       (adc_so),
        .adc_cs       (adc_cs),
        .adc_sclk     (adc_sclk),
        .det_en       (det_en),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .lead_err     (lead_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ADC model: word loaded at cs fall, MSB first, new bit on each sclk fall
    logic [15:0] word = 16'h0;
    logic [15:0] wq[$];
    logic [15:0] sh = 16'h0;

    always @(negedge adc_cs) begin
        if (wq.size() > 0) sh = wq.pop_front();
        else sh = word;
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs) begin
            adc_so = sh[15];
            sh = sh << 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cs_falls = 0, cs_rises = 0;
    int t_det_rise = 0, t_det_fall = 0, t_cs_fall = 0, t_cs_rise = 0;
    int win_rises = 0, last_rises = 0, wins = 0;
    int run_len = 0, hi_run = 0;
    int ph_min = 999, ph_max = 0, gap_min = 999, gap_max = 0;
    bit armed = 0, win_ok = 0, gap_ok = 0, valid_seen = 0;
    logic p_cs = 1'b1, p_sclk = 1'b1, p_det = 1'b0;
    logic [11:0] got[$];
    int t_xfer[$];

    always @(negedge clk) begin
        if (det_en && !p_det) t_det_rise = cyc;
        if (!det_en && p_det) t_det_fall = cyc;
        if (!adc_cs && p_cs) begin
            cs_falls++;
            t_cs_fall = cyc;
            win_rises = 0;
            win_ok = armed;
            if (gap_ok) begin
                if (hi_run < gap_min) gap_min = hi_run;
                if (hi_run > gap_max) gap_max = hi_run;
            end
            gap_ok = 0;
        end
        if (adc_cs && !p_cs) begin
            cs_rises++;
            t_cs_rise = cyc;
            if (win_ok) begin
                last_rises = win_rises;
                wins++;
                if (run_len < ph_min) ph_min = run_len;
                if (run_len > ph_max) ph_max = run_len;
            end
            gap_ok = win_ok;
            win_ok = 0;
            hi_run = 0;
        end
        if (adc_cs) hi_run++;
        if (!adc_cs) begin
            if (!p_cs && adc_sclk == p_sclk) begin
                run_len++;
            end else begin
                if (!p_cs && win_ok) begin
                    if (run_len < ph_min) ph_min = run_len;
                    if (run_len > ph_max) ph_max = run_len;
                end
                run_len = 1;
            end
            if (adc_sclk && !p_sclk) win_rises++;
        end
        if (sample_valid) valid_seen = 1;
        if (sample_valid && sample_ready) begin
            got.push_back(sample_data);
            t_xfer.push_back(cyc);
        end
        p_cs = adc_cs;
        p_sclk = adc_sclk;
        p_det = det_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_falls(input int n, input string tag);
        int tgt;
        bit ok;
        tgt = cs_falls + n;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cs_falls >= tgt) begin ok = 1; break; end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    task automatic wait_rises(input int n, input string tag);
        int tgt;
        bit ok;
        tgt = cs_rises + n;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cs_rises >= tgt) begin ok = 1; break; end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    task automatic wait_xfers(input int n, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (got.size() >= n) begin ok = 1; break; end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    task automatic wait_bits(input int n, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!adc_cs && win_rises >= n) begin ok = 1; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_det_low(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!det_en) begin ok = 1; break; end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    function automatic logic [11:0] exp_data(input logic [15:0] w);
        return 12'(w % 16'd4096);
    endfunction

    function automatic logic exp_lead(input logic [15:0] w);
        return (w >> 12) != 0;
    endfunction

    logic [15:0] w, w2;
    int          n;
    int          sum;

    initial begin
        tick(3);
        check("rst_cs", adc_cs, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_det", det_en, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_ovr", overrun, 0);
        check("rst_lead", lead_err, 0);
        reset = 1'b0;
        tick(2);

`ifdef ADC_AVG_EN
        wq = {16'd100, 16'd101, 16'd102, 16'd103};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom_range(0, 4095));
            wq.push_back(w);
            sum += int'(w);
        end
        word = 16'd7;
        got.delete();
        run = 1'b1;
        wait_rises(3, "avg_f3_to");
        tick(5);
        check("avg_none_before", got.size(), 0);
        wait_rises(1, "avg_f4_to");
        tick(5);
        check("avg_one", got.size(), 1);
        check("avg_val", got[0], (100 + 101 + 102 + 103) / 4);
        check("avg_lead", lead_err, 0);
        wait_rises(4, "avg_f8_to");
        tick(5);
        check("avg_two", got.size(), 2);
        check("avg_rand", got[1], sum / 4);
        check("avg_ovr", overrun, 0);
`else
        // settle delay and steady delivery
        word = 16'h0ABC;
        run = 1'b1;
        wait_falls(1, "first_cs_to");
        check("settle_len", t_cs_fall - t_det_rise, 1000);
        check("det_on", det_en, 1);
        wait_xfers(3, "abc_to");
        check("abc_0", got[0], exp_data(16'h0ABC));
        check("abc_2", got[2], exp_data(16'h0ABC));
        check("period_1", t_xfer[1] - t_xfer[0], 140);
        check("period_2", t_xfer[2] - t_xfer[1], 140);
        check("abc_lead", lead_err, 0);

        // pin timing
        word = 16'h0555;
        wait_falls(1, "p555_to");
        got.delete();
        ph_min = 999; ph_max = 0; gap_min = 999; gap_max = 0; wins = 0;
        armed = 1;
        wait_falls(2, "pin_win_to");
        wait_rises(1, "pin_end_to");
        armed = 0;
        check("pin_wins", wins, 2);
        check("pin_rises", last_rises, 16);
        check("pin_ph_min", ph_min, 4);
        check("pin_ph_max", ph_max, 4);
        check("pin_gap_min", gap_min, 8);
        check("pin_gap_max", gap_max, 8);
        wait_xfers(2, "x555_to");
        check("x555_0", got[0], exp_data(16'h0555));
        check("x555_1", got[1], exp_data(16'h0555));

        // backpressure
        w = 16'($urandom_range(0, 4095));
        w2 = w ^ 16'h0A5A;
        word = w;
        wait_falls(1, "bp_start_to");
        sample_ready = 1'b0;
        word = w2;
        wait_rises(3, "bp_frames_to");
        tick(5);
        check("bp_valid", sample_valid, 1);
        check("bp_hold", sample_data, exp_data(w));
        check("bp_ovr", overrun, 1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("bp_ovr_clr", overrun, 0);
        got.delete();
        sample_ready = 1'b1;
        wait_xfers(2, "bp_resume_to");
        check("bp_first", got[0], exp_data(w));
        check("bp_next", got[1], exp_data(w2));

        // leading-bit error
        word = 16'h8123;
        wait_falls(1, "lead_start_to");
        got.delete();
        wait_xfers(1, "lead_to");
        check("lead_data", got[0], exp_data(16'h8123));
        check("lead_set", lead_err, exp_lead(16'h8123));
        tick(5);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("lead_clr", lead_err, 0);

        // random words against the frame rules
        for (int k = 0; k < 4; k++) begin
            w = 16'($urandom);
            word = w;
            wait_falls(1, "rnd_start_to");
            clear_flags = 1'b1;
            tick(1);
            clear_flags = 1'b0;
            got.delete();
            wait_xfers(1, "rnd_to");
            check("rnd_data", got[0], exp_data(w));
            check("rnd_lead", lead_err, exp_lead(w));
        end

        // run dropped mid-frame
        w = 16'($urandom_range(0, 4095));
        word = w;
        wait_falls(1, "drop_start_to");
        got.delete();
        wait_bits(5, "drop_bit5_to");
        run = 1'b0;
        wait_xfers(1, "drop_xfer_to");
        check("drop_data", got[0], exp_data(w));
        wait_det_low("drop_det_to");
        check("drop_quiet", t_det_fall - t_cs_rise, 8);
        n = cs_falls;
        tick(60);
        check("drop_no_conv", cs_falls, n);
        check("drop_cs", adc_cs, 1);

        // reset mid-frame
        run = 1'b1;
        wait_falls(1, "rst_start_to");
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!adc_cs && !adc_sclk) begin n = 1; break; end
        end
        check("rst_low_phase", n, 1);
        #2;
        reset = 1'b1;
        valid_seen = 0;
        #1;
        check("rst_mid_cs", adc_cs, 1);
        check("rst_mid_sclk", adc_sclk, 1);
        run = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(300);
        check("rst_no_valid", valid_seen, 0);
        check("rst_det_off", det_en, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
